pipe_stage_chain: RTL

Parametrised chain of pipeline registers with per-stage valid, stall and flush control. It replaces hand-written inter-stage register banks with `STAGES` uniform stages, each carrying a `WIDTH`-bit payload. Stall back-pressure propagates upstream only through occupied stages, so bubbles collapse. It sits between the CPU datapath stages and is driven by the hazard unit.

---
 rtl/pipe_chain_pkg.sv | 20 ++
 rtl/pipe_stage.sv | 59 +++++
 rtl/pipe_stage_chain.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipe_chain_pkg.sv
// pipe_chain_pkg: shared types and helpers for pipe_stage_chain.
// Stage command enum, perf counter width, saturating increment.
package pipe_chain_pkg;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_HOLD,
    OP_BUBBLE,
    OP_KILL
  } stage_op_t;

  localparam int PERF_W = 32;

  function automatic logic [PERF_W-1:0] sat_inc(
    input logic [PERF_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one payload register plus valid bit.
// Next state is selected by the stage_op_t command from the top.
module pipe_stage
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  stage_op_t        op_i,
  input  logic [WIDTH-1:0] prev_data_i,
  input  logic             prev_valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Cleared stages always carry zero data so downstream sees a NOP.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    unique case (op_i)
      OP_LOAD: begin
        data_d  = prev_data_i;
        valid_d = prev_valid_i;
      end
      OP_HOLD: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
      OP_BUBBLE,
      OP_KILL: begin
        data_d  = '0;
        valid_d = 1'b0;
      end
      default: begin
        data_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep register chain with stall/flush.
// PIPE_PERF_CNT_EN adds saturating stall and flush counters.
module pipe_stage_chain
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES-1:0]         out_valid,
  output logic [STAGES*WIDTH-1:0]   out_data,
  output logic [PERF_W-1:0]         stall_cnt,
  output logic [PERF_W-1:0]         flush_cnt
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] bub;
  stage_op_t         op [STAGES];

  // Back-pressure walks upstream only through occupied stages.
  always_comb begin
    logic h;
    h    = 1'b0;
    hold = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      h       = out_valid[k] & (stall[k] | h);
      hold[k] = h;
    end
  end

  // A flush at stage j kills j and every younger stage.
  always_comb begin
    logic f;
    f    = 1'b0;
    kill = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      f       = f | flush[k];
      kill[k] = f;
    end
  end

  assign bub      = {hold[STAGES-2:0], 1'b0};
  assign in_ready = ~hold[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] prev_d;
    logic             prev_v;

    if (k == 0) begin : g_head
      assign prev_v = in_valid;
      assign prev_d = in_valid ? in_data : '0;
    end else begin : g_body
      assign prev_v = out_valid[k-1];
      assign prev_d = out_data[(k-1)*WIDTH +: WIDTH];
    end

    // Priority: kill, hold, bubble, load.
    always_comb begin
      op[k] = OP_LOAD;
      if (kill[k])      op[k] = OP_KILL;
      else if (hold[k]) op[k] = OP_HOLD;
      else if (bub[k])  op[k] = OP_BUBBLE;
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .CLK          (CLK),
      .nRST         (nRST),
      .op_i         (op[k]),
      .prev_data_i  (prev_d),
      .prev_valid_i (prev_v),
      .data_o       (out_data[k*WIDTH +: WIDTH]),
      .valid_o      (out_valid[k])
    );
  end

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Count back-pressure and flush cycles, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!in_ready) stall_cnt_d = sat_inc(stall_cnt_q);
    if (|flush)    flush_cnt_d = sat_inc(flush_cnt_q);
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
